// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the IM fetch address, selects the next PC
// (sequential / branch / jump / jump-register), holds on stall and traps illegal targets.
module pc_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fault,
    output logic [1:0]  state,
    output logic [31:0] instr_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        FAULT = 2'b11
    } state_t;

    // One past the last legal byte address; 33 bits so a window ending at 2^32 still compares.
    localparam logic [32:0] IM_END = {1'b0, PC_RESET} + (33'(IM_DEPTH) << 2);

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        cnt_q;
    logic               fault_q;

    logic [31:0]        pc_plus4_w;
    logic signed [31:0] br_off;
    logic [31:0]        pc_d;
    logic               legal_d;

    always_comb begin
        pc_plus4_w = pc_q + 32'd4;
        br_off     = {{14{imm16[15]}}, imm16, 2'b00};
        pc_d       = pc_plus4_w;
        case (npc_sel)
            2'b00:   pc_d = pc_plus4_w;
            2'b01:   pc_d = br_taken ? (pc_plus4_w + $unsigned(br_off)) : pc_plus4_w;
            2'b10:   pc_d = {pc_q[31:28], imm26, 2'b00};
            default: pc_d = ra;
        endcase
        legal_d = (pc_d[1:0] == 2'b00)
               && ({1'b0, pc_d} >= {1'b0, PC_RESET})
               && ({1'b0, pc_d} <  IM_END);
    end

    // Stall outranks fault detection; FAULT is left only through reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= PC_RESET;
            cnt_q   <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN, STALL: begin
                    if (stall) begin
                        state_q <= STALL;
                    end else if (legal_d) begin
                        pc_q    <= pc_d;
                        cnt_q   <= cnt_q + 32'd1;
                        state_q <= RUN;
                    end else begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= BOOT;
            endcase
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign fetch_valid = (state_q == RUN) || (state_q == STALL);
    assign fault       = fault_q;
    assign state       = state_q;
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the next-PC rules.
module tb_pc_sequencer;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int unsigned DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        br_taken = 1'b0;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] imm26 = 26'h0;
    logic [31:0] ra = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] pc, pc_plus4, instr_cnt;
    logic        fetch_valid, fault;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Model state: 0 BOOT, 1 RUN, 2 STALL, 3 FAULT
    logic [31:0] m_pc    = BASE;
    logic [31:0] m_cnt   = 32'd0;
    int          m_state = 0;
    logic        m_fault = 1'b0;

    pc_sequencer #(.PC_RESET(BASE), .IM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .npc_sel(npc_sel), .br_taken(br_taken),
        .imm16(imm16), .imm26(imm26), .ra(ra), .stall(stall),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .fault(fault),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] cur);
        int off;
        off = int'($signed(imm16)) * 4;
        case (npc_sel)
            2'd0:    return cur + 32'd4;
            2'd1:    return br_taken ? cur + 32'd4 + 32'(off) : cur + 32'd4;
            2'd2:    return (cur & 32'hF000_0000) | (32'(imm26) * 32'd4);
            default: return ra;
        endcase
    endfunction

    function automatic bit model_legal(input logic [31:0] t);
        return (t % 4 == 0) && (longint'(t) >= longint'(BASE))
            && (longint'(t) < longint'(BASE) + 4 * longint'(DEPTH));
    endfunction

    task automatic model_reset();
        m_pc = BASE; m_cnt = 0; m_state = 0; m_fault = 1'b0;
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clk) begin
        logic [31:0] t;
        if (!reset) model_reset();
        else if (m_state == 0) m_state = 1;
        else if (m_state != 3) begin
            t = model_target(m_pc);
            if (stall) m_state = 2;
            else if (model_legal(t)) begin
                m_pc = t; m_cnt = m_cnt + 1; m_state = 1;
            end else begin
                m_state = 3; m_fault = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("state", 32'(state), 32'(m_state));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fetch_valid", 32'(fetch_valid), 32'(m_state == 1 || m_state == 2));
        chk("instr_cnt", instr_cnt, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] sel, input logic bt, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] r, input logic st);
        npc_sel = sel; br_taken = bt; imm16 = i16; imm26 = i26; ra = r; stall = st;
        tick();
    endtask

    task automatic boot();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] cnt_snap;
        @(negedge clk);
        #1;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_pc_plus4", pc_plus4, 32'h3004);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);

        reset = 1'b1;
        tick();
        chk("boot_to_run_pc", pc, 32'h3000);
        chk("boot_to_run_fv", 32'(fetch_valid), 32'd1);
        tick(); tick(); tick();
        chk("seq_pc", pc, 32'h300C);
        chk("seq_cnt", instr_cnt, 32'd3);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3010, 1'b0);
        step(2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0);
        chk("br_taken_pc", pc, 32'h3004);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3010, 1'b0);
        step(2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0);
        chk("br_not_taken_pc", pc, 32'h3014);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3000, 1'b0);
        step(2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0, 1'b0);
        chk("jump_pc", pc, 32'h3040);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3100, 1'b0);
        chk("jr_pc", pc, 32'h3100);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3008, 1'b0);
        cnt_snap = instr_cnt;
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
        chk("stall_pc", pc, 32'h3008);
        chk("stall_state", 32'(state), 32'd2);
        chk("stall_cnt", instr_cnt, cnt_snap);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("unstall_pc", pc, 32'h300C);
        chk("unstall_state", 32'(state), 32'd1);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h7000, 1'b1);
        chk("stall_hides_fault", 32'(fault), 32'd0);
        chk("stall_hides_state", 32'(state), 32'd2);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b0);
        chk("misalign_fault", 32'(fault), 32'd1);
        chk("misalign_state", 32'(state), 32'd3);
        chk("misalign_pc", pc, 32'h300C);
        chk("misalign_fv", 32'(fetch_valid), 32'd0);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h3100, 1'b0);
        chk("fault_frozen_pc", pc, 32'h300C);
        chk("fault_frozen_state", 32'(state), 32'd3);

        reset = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'h3000);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        chk("async_rst_cnt", instr_cnt, 32'd0);
        chk("async_rst_fv", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h7000, 1'b0);
        chk("above_window_fault", 32'(fault), 32'd1);

        boot();
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h6FFC, 1'b0);
        chk("last_word_pc", pc, 32'h6FFC);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("run_off_end_fault", 32'(fault), 32'd1);
        chk("run_off_end_pc", pc, 32'h6FFC);

        boot();
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h2FFC, 1'b0);
        chk("below_window_fault", 32'(fault), 32'd1);

        boot();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  sel;
            logic [31:0] r;
            int          k;
            sel = 2'($urandom_range(0, 3));
            k = int'($urandom_range(0, 19));
            if (k == 0)      r = $urandom();
            else if (k == 1) r = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else             r = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
            npc_sel  = sel;
            br_taken = 1'($urandom_range(0, 1));
            imm16    = 16'($signed(int'($urandom_range(0, 160)) - 80));
            imm26    = 26'(32'h0C00 + $urandom_range(0, DEPTH + 2));
            ra       = r;
            stall    = ($urandom_range(0, 4) == 0);
            if ((m_state == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0)
                reset = 1'b0;
            else
                reset = 1'b1;
            tick();
        end
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
